serial_mem_target: RTL and testbench
====================================

// Module: serial_mem_target
// PURPOSE
// - Downstream target for the 10-phase byte-serial CPU bus: consumes the address, write-data and
//   read/write flag bytes the CPU handler emits, and returns the read word on the data pins.
// - Holds a word-addressed RAM backing store.
// - Runs a phase counter in lockstep with the handler; both leave reset together on the shared clock.
// PARAMETERS
// - ADDR_W     6             word-address bits; RAM holds 2**ADDR_W 32-bit words
// - BASE_ADDR  32'h0000_0000 byte address of word 0; must be 4-byte aligned
// PORTS
// - clk       in   1  single clock; all state updates on posedge
// - rst       in   1  synchronous, active-high reset
// - addr_in   in   8  handler address-byte pins; bit0 carries the write flag in phase 5
// - wdata_in  in   8  handler data pins while the handler drives them (phases 1-4)
// - rd_byte   out  8  read-data byte returned to the handler data pins
// - rd_oe     out  1  1 = target drives rd_byte onto the shared data pins
// - phase     out  4  current frame phase, 0..9
// - err       out  1  one-cycle pulse: previous command was out of range
// BEHAVIOUR
// - Reset values: phase=0, rd_byte=0, rd_oe=0, err=0, address and write-data shift regs=0.
// - The RAM array is not reset; contents survive rst.
// - Phase counter: phase <= (phase==9) ? 0 : phase+1 every clk. Frame = 10 cycles.
// - Capture in phases 1-4: at the posedge where phase==k, addr byte k-1 <= addr_in and
//   wdata byte k-1 <= wdata_in. Bytes are little-endian (phase 1 = bits 7:0, phase 4 = bits 31:24).
// - Command in phase 5: at the posedge where phase==5, wr = addr_in[0]. 1 = write, 0 = read.
//   - addr_in[7:1] and wdata_in are ignored in phase 5.
// - Decode: off = addr - BASE_ADDR, a 32-bit wrap-around subtract. addr[1:0] are ignored.
//   - In range iff off[31:ADDR_W+2]==0; the word index is off[ADDR_W+1:2].
// - Write, in range: RAM[idx] <= wdata at the phase-5 posedge. No read data is returned.
//   - rd_oe stays 0 for the whole frame.
// - Read, in range: rd_byte and rd_oe are registered outputs.
//   - While phase==6..9: rd_byte = RAM[idx] byte (phase-6), little-endian, and rd_oe=1.
//   - The phase-6 byte is loaded at the phase-5 posedge, so each byte is stable across the
//     handler's sampling negedge.
// - Out of range: writes are dropped. Reads return 8'h00 with rd_oe=1 during phases 6-9.
//   - err=1 for exactly the cycle in which phase==6. Otherwise err=0.
// - Phases 0 and 6-9: the address and write-data inputs are ignored.
// - rd_oe=0 and rd_byte=0 in every phase except 6-9 of a read frame.
// - Read-after-write: a read in frame N+1 returns the data written in frame N. No stall is needed.
// - Reset mid-frame: the frame is abandoned. A write takes effect only if its phase-5 edge
//   completed before rst. rd_oe drops the cycle after rst is sampled.
// CONFIGURATION
// - ADDR_MIRROR_EN defined: the range check is skipped. idx = off[ADDR_W+1:2] for every address,
//   so upper bits alias onto the RAM. err is tied to 0.
// - ADDR_MIRROR_EN undefined: out-of-range handling is exactly as stated under BEHAVIOUR.
// TESTING
// - Reset, then 20 idle cycles -> phase sequence 0,1..9,0,1..9; rd_oe=0; err=0; rd_byte=0.
// - Write frame to addr 32'h0000_0010, data 32'hDEADBEEF, then a read frame to the same address
//   -> phases 6..9 give rd_byte EF,BE,AD,DE with rd_oe=1; err stays 0.
// - Read frame to 32'h0000_0013, with no prior write to that word except DEADBEEF at 0x10
//   -> returns EF,BE,AD,DE, because addr[1:0] are ignored.
// - ADDR_W=6, read of 32'h0000_0100 -> rd_byte 00,00,00,00; rd_oe=1; err=1 only at phase 6.
//   - Write 32'h12345678 to 0x100, then read 0x000 -> word 0 is unchanged.
//   - With ADDR_MIRROR_EN: the same write lands in word 0, and err=0.
// - Assert rst at phase 3 of a write frame to 0x20, after having written 32'h0 there
//   -> RAM[8] remains 0; next phase=0; rd_oe=0.
// - Back-to-back write/read frames over all 64 words with data = ~idx -> every read matches.

Source files
------------

// File: rtl/serial_mem_target.sv
// rtl/serial_mem_target.sv - byte-serial bus target with word RAM; define ADDR_MIRROR_EN to alias out-of-range addresses
module serial_mem_target #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic [7:0] rd_byte,
    output logic       rd_oe,
    output logic [3:0] phase,
    output logic       err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [3:0]        phase_q, phase_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rd_word_q, rd_word_d;
    logic [7:0]        rd_byte_q, rd_byte_d;
    logic              rd_oe_q, rd_oe_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              cmd_wr;
    logic              mem_we;

    // Address decode of the captured address and the phase-5 command flag
    always_comb begin
        off    = addr_q - BASE_ADDR;
        idx    = off[ADDR_W+1:2];
`ifdef ADDR_MIRROR_EN
        in_range = 1'b1;
`else
        in_range = ((off >> (ADDR_W + 2)) == 32'd0);
`endif
        cmd_wr = addr_in[0];
        mem_we = (phase_q == 4'd5) && cmd_wr && in_range;
    end

    // Next-state logic: phase counter, byte capture, read-word shifter, error pulse
    always_comb begin
        phase_d   = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_word_d = rd_word_q;
        rd_byte_d = 8'h00;
        rd_oe_d   = 1'b0;
        err_d     = 1'b0;
        case (phase_q)
            4'd1: begin
                addr_d[7:0]  = addr_in;
                wdata_d[7:0] = wdata_in;
            end
            4'd2: begin
                addr_d[15:8]  = addr_in;
                wdata_d[15:8] = wdata_in;
            end
            4'd3: begin
                addr_d[23:16]  = addr_in;
                wdata_d[23:16] = wdata_in;
            end
            4'd4: begin
                addr_d[31:24]  = addr_in;
                wdata_d[31:24] = wdata_in;
            end
            4'd5: begin
                // Byte 0 is presented during phase 6, so it is loaded here
                if (!cmd_wr) begin
                    rd_word_d = in_range ? mem[idx] : 32'h0;
                    rd_byte_d = rd_word_d[7:0];
                    rd_oe_d   = 1'b1;
                end
`ifndef ADDR_MIRROR_EN
                err_d = !in_range;
`endif
            end
            4'd6, 4'd7, 4'd8: begin
                if (rd_oe_q) begin
                    rd_word_d = rd_word_q >> 8;
                    rd_byte_d = rd_word_d[7:0];
                    rd_oe_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rd_word_q <= 32'h0;
            rd_byte_q <= 8'h00;
            rd_oe_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_word_q <= rd_word_d;
            rd_byte_q <= rd_byte_d;
            rd_oe_q   <= rd_oe_d;
            err_q     <= err_d;
        end
    end

    // RAM write; contents are not reset, and a write coinciding with reset is abandoned
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[idx] <= wdata_q;
        end
    end

    assign phase   = phase_q;
    assign rd_byte = rd_byte_q;
    assign rd_oe   = rd_oe_q;
    assign err     = err_q;

endmodule

// File: tb/tb_serial_mem_target.sv
// tb/tb_serial_mem_target.sv - self-checking bench for serial_mem_target against a word-array model
module tb_serial_mem_target;

    localparam int          WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr_in = 8'h00;
    logic [7:0] wdata_in = 8'h00;
    logic [7:0] rd_byte;
    logic       rd_oe;
    logic [3:0] phase;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [WORDS];

    always #5 clk = ~clk;

    serial_mem_target #(.ADDR_W(6), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_byte(rd_byte), .rd_oe(rd_oe), .phase(phase), .err(err)
    );

    function automatic logic ref_in_range(input logic [31:0] a);
`ifdef ADDR_MIRROR_EN
        return 1'b1;
`else
        return (a - BASE) < 32'(WORDS * 4);
`endif
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'(((a - BASE) / 32'd4) % 32'(WORDS));
    endfunction

    // Reference model: applies one command and returns what the bus should show
    task automatic ref_apply(input logic [31:0] a, input logic [31:0] d, input bit wr,
                             output logic [31:0] ew, output logic [3:0] eo, output logic [9:0] ee);
        ew = 32'h0;
        eo = 4'h0;
        ee = 10'h0;
        if (!ref_in_range(a)) ee[6] = 1'b1;
        if (wr) begin
            if (ref_in_range(a)) ref_mem[ref_idx(a)] = d;
        end else begin
            eo = 4'hF;
            if (ref_in_range(a)) ew = ref_mem[ref_idx(a)];
        end
    endtask

    // Drives one full frame starting at phase 1 and records what the target returned
    task automatic run_frame(input logic [31:0] a, input logic [31:0] d, input bit wr,
                             output logic [31:0] gw, output logic [3:0] go,
                             output logic [9:0] ge, output bit stray);
        int n;
        int pe;
        gw = 32'h0;
        go = 4'h0;
        ge = 10'h0;
        stray = 1'b0;
        n = 0;
        while (phase !== 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (phase !== 4'd1) begin
            errors++;
            $display("FAIL frame_sync phase=%0d required=1", phase);
        end
        for (int p = 1; p <= 10; p++) begin
            pe = p % 10;
            if (phase !== 4'(pe)) stray = 1'b1;
            if (err === 1'b1) ge[pe] = 1'b1;
            else if (err !== 1'b0) stray = 1'b1;
            if (p >= 6 && p <= 9) begin
                gw[8*(p-6) +: 8] = rd_byte;
                go[p-6] = rd_oe;
            end else if (rd_oe !== 1'b0 || rd_byte !== 8'h00) begin
                stray = 1'b1;
            end
            if (p <= 4) begin
                addr_in  = a[8*(p-1) +: 8];
                wdata_in = d[8*(p-1) +: 8];
            end else if (p == 5) begin
                addr_in  = {7'($urandom), wr};
                wdata_in = 8'($urandom);
            end else if (p < 10) begin
                addr_in  = 8'($urandom);
                wdata_in = 8'($urandom);
            end else begin
                addr_in  = 8'h00;
                wdata_in = 8'h00;
            end
            if (p < 10) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({phase, rd_oe, err, rd_byte} !== 15'h0) begin
            errors++;
            $display("FAIL reset_state phase=%0d oe=%b err=%b byte=%h required 0", phase, rd_oe, err, rd_byte);
        end
        rst = 1'b0;
        // Idle frames write 0 to word 0 (flag set only in phase 5), never out of range
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({phase, rd_oe, err, rd_byte} !== {4'(i % 10), 1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL idle_cycle%0d phase=%0d oe=%b err=%b byte=%h required phase=%0d oe=0 err=0 byte=00",
                         i, phase, rd_oe, err, rd_byte, i % 10);
            end
            addr_in  = (phase == 4'd5) ? 8'h01 : 8'h00;
            wdata_in = 8'h00;
            @(negedge clk);
        end
        ref_mem[0] = 32'h0;
        addr_in = 8'h00;
    endtask

    task automatic test_write_read;
        logic [31:0] ta [3] = '{32'h10, 32'h10, 32'h13};
        bit          tw [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] gw, ew;
        logic [3:0]  go, eo;
        logic [9:0]  ge, ee;
        bit          st;
        for (int i = 0; i < 3; i++) begin
            ref_apply(ta[i], 32'hDEADBEEF, tw[i], ew, eo, ee);
            run_frame(ta[i], 32'hDEADBEEF, tw[i], gw, go, ge, st);
            checks++;
            if ({gw, go, ge, st} !== {ew, eo, ee, 1'b0}) begin
                errors++;
                $display("FAIL write_read%0d word=%h oe=%h err=%h stray=%b required word=%h oe=%h err=%h stray=0",
                         i, gw, go, ge, st, ew, eo, ee);
            end
        end
        checks++;
        if (gw !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL unaligned_read word=%h required deadbeef", gw);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] ta [3] = '{32'h100, 32'h100, 32'h000};
        bit          tw [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] gw, ew;
        logic [3:0]  go, eo;
        logic [9:0]  ge, ee;
        bit          st;
        for (int i = 0; i < 3; i++) begin
            ref_apply(ta[i], 32'h12345678, tw[i], ew, eo, ee);
            run_frame(ta[i], 32'h12345678, tw[i], gw, go, ge, st);
            checks++;
            if ({gw, go, ge, st} !== {ew, eo, ee, 1'b0}) begin
                errors++;
                $display("FAIL out_of_range%0d word=%h oe=%h err=%h stray=%b required word=%h oe=%h err=%h stray=0",
                         i, gw, go, ge, st, ew, eo, ee);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] gw, ew;
        logic [3:0]  go, eo;
        logic [9:0]  ge, ee;
        bit          st;
        int          n;
        logic [31:0] a;
        ref_apply(32'h20, 32'h0, 1'b1, ew, eo, ee);
        run_frame(32'h20, 32'h0, 1'b1, gw, go, ge, st);
        // Abandoned write: reset sampled at the phase-3 edge
        a = 32'h20;
        n = 0;
        while (phase !== 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int p = 1; p <= 3; p++) begin
            addr_in  = a[8*(p-1) +: 8];
            wdata_in = 8'hA5;
            if (p == 3) rst = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({phase, rd_oe} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_write_frame phase=%0d oe=%b required phase=0 oe=0", phase, rd_oe);
        end
        rst = 1'b0;
        addr_in = 8'h00;
        ref_apply(32'h20, 32'h0, 1'b0, ew, eo, ee);
        run_frame(32'h20, 32'h0, 1'b0, gw, go, ge, st);
        checks++;
        if ({gw, go, ge, st} !== {ew, eo, ee, 1'b0}) begin
            errors++;
            $display("FAIL reset_abandoned_write word=%h oe=%h err=%h stray=%b required word=%h oe=%h err=%h",
                     gw, go, ge, st, ew, eo, ee);
        end
        // Read frame cut by reset during phase 7
        a = 32'h10;
        n = 0;
        while (phase !== 4'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int p = 1; p <= 7; p++) begin
            addr_in  = (p <= 4) ? a[8*(p-1) +: 8] : 8'h00;
            wdata_in = 8'h00;
            if (p == 7) begin
                checks++;
                if (rd_oe !== 1'b1) begin
                    errors++;
                    $display("FAIL read_before_reset oe=%b required 1", rd_oe);
                end
                rst = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if ({phase, rd_oe, rd_byte} !== 13'h0) begin
            errors++;
            $display("FAIL reset_read_frame phase=%0d oe=%b byte=%h required 0,0,00", phase, rd_oe, rd_byte);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] gw, ew, a;
        logic [3:0]  go, eo;
        logic [9:0]  ge, ee;
        bit          st;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < WORDS; i++) begin
                a = BASE + 32'(4 * i);
                ref_apply(a, ~32'(i), pass == 0, ew, eo, ee);
                run_frame(a, ~32'(i), pass == 0, gw, go, ge, st);
                checks++;
                if ({gw, go, ge, st} !== {ew, eo, ee, 1'b0}) begin
                    errors++;
                    $display("FAIL sweep pass%0d word%0d got=%h oe=%h err=%h stray=%b required=%h oe=%h err=%h",
                             pass, i, gw, go, ge, st, ew, eo, ee);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] gw, ew, a, d;
        logic [3:0]  go, eo;
        logic [9:0]  ge, ee;
        bit          st, wr;
        for (int i = 0; i < 200; i++) begin
            a  = BASE + 32'($urandom_range(0, 511));
            d  = $urandom;
            wr = 1'($urandom);
            ref_apply(a, d, wr, ew, eo, ee);
            run_frame(a, d, wr, gw, go, ge, st);
            checks++;
            if ({gw, go, ge, st} !== {ew, eo, ee, 1'b0}) begin
                errors++;
                $display("FAIL random%0d addr=%h wr=%b got=%h oe=%h err=%h stray=%b required=%h oe=%h err=%h",
                         i, a, wr, gw, go, ge, st, ew, eo, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
